// File: rtl/pad_bank_pkg.sv
// Shared types and sizing helpers for the pad bank: per-pad FSM state and
// counter width derivation used by the channel logic.
package pad_bank_pkg;

   typedef enum logic [1:0] {
      PAD_HIZ   = 2'd0,
      PAD_WAIT  = 2'd1,
      PAD_DRIVE = 2'd2
   } pad_state_t;

   localparam int DEF_N_PADS      = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_LEN    = 3;
   localparam int DEF_TURN_CYCLES = 2;

   // Bits needed for a counter that holds 0 .. max_count-1, never less than one.
   function automatic int cnt_width(input int max_count);
      return (max_count <= 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/pad_bank_if.sv
// Core-side and pad-side bus of the pad bank; the bank itself sits on the
// slave modport, the core/pad environment on the master modport.
interface pad_bank_if
   import pad_bank_pkg::*;
#(
   parameter int N_PADS = DEF_N_PADS
);

   logic [N_PADS-1:0] out_val;
   logic [N_PADS-1:0] oe_req;
   logic              hiz_all;
   logic [N_PADS-1:0] pad_i;
   logic [N_PADS-1:0] in_val;
   logic [N_PADS-1:0] in_rise;
   logic [N_PADS-1:0] in_fall;
   logic [N_PADS-1:0] drv;
   logic [N_PADS-1:0] pad_o;
   logic [N_PADS-1:0] pad_t;

   modport master (
      output out_val, oe_req, hiz_all, pad_i,
      input  in_val, in_rise, in_fall, drv, pad_o, pad_t
   );

   modport slave (
      input  out_val, oe_req, hiz_all, pad_i,
      output in_val, in_rise, in_fall, drv, pad_o, pad_t
   );

endinterface

// File: rtl/pad_bank_chan.sv
// One bidirectional pad: HIZ/WAIT/DRIVE turnaround FSM, registered output data,
// and a synchronised, glitch-filtered input path with edge pulses.
module pad_bank_chan
   import pad_bank_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   FILT_LEN    = DEF_FILT_LEN,
   parameter int   TURN_CYCLES = DEF_TURN_CYCLES,
   parameter logic IDLE_BIT    = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic out_val,
   input  logic oe_req,
   input  logic hiz,
   input  logic pad_i,
   output logic in_val,
   output logic in_rise,
   output logic in_fall,
   output logic drv,
   output logic pad_o,
   output logic pad_t
);

   localparam int FW = cnt_width(FILT_LEN);
   localparam int TW = cnt_width((TURN_CYCLES > 0) ? TURN_CYCLES : 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

   pad_state_t state, next_state;
   logic [TW-1:0] wait_cnt, wait_cnt_next;
   logic          request;
   logic          is_drive;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   filt_q;
   logic [FW-1:0]          filt_cnt;
   logic                   rise_q;
   logic                   fall_q;
   logic                   pad_o_q;

   assign request  = oe_req & ~hiz;
   assign is_drive = (state == PAD_DRIVE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= PAD_HIZ;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Losing the request (or a bank-wide hiz) always drops straight back to HIZ.
   always_comb begin
      next_state    = state;
      wait_cnt_next = '0;
      case (state)
         PAD_HIZ: begin
            if (request) begin
               next_state = (TURN_CYCLES > 0) ? PAD_WAIT : PAD_DRIVE;
            end
         end
         PAD_WAIT: begin
            if (!request) begin
               next_state = PAD_HIZ;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = PAD_DRIVE;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         PAD_DRIVE: begin
            if (!request) begin
               next_state = PAD_HIZ;
            end
         end
         default: next_state = PAD_HIZ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{IDLE_BIT}};
         pad_o_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
         pad_o_q <= out_val;
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // While driving we see our own output, so track it silently instead of
   // filtering; this keeps the release from DRIVE free of spurious edges.
   always_ff @(posedge clock) begin
      if (reset) begin
         filt_q   <= IDLE_BIT;
         filt_cnt <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else if (is_drive) begin
         filt_q   <= synced;
         filt_cnt <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (synced == filt_q) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_q   <= synced;
            filt_cnt <= '0;
            rise_q   <= synced;
            fall_q   <= ~synced;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign in_val  = is_drive ? IDLE_BIT : filt_q;
   assign in_rise = rise_q & ~is_drive;
   assign in_fall = fall_q & ~is_drive;
   assign drv     = is_drive;
   assign pad_t   = ~is_drive;
   assign pad_o   = pad_o_q;

endmodule

// File: rtl/pad_bank_io.sv
// Bank of N_PADS independent bidirectional pad channels; this level only fans
// out the bank-wide hiz_all and wires each channel onto the bus bits.
module pad_bank_io
   import pad_bank_pkg::*;
#(
   parameter int                N_PADS      = DEF_N_PADS,
   parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int                FILT_LEN    = DEF_FILT_LEN,
   parameter int                TURN_CYCLES = DEF_TURN_CYCLES,
   parameter logic [N_PADS-1:0] IDLE_VAL    = '0
) (
   input logic       clock,
   input logic       reset,
   pad_bank_if.slave bus
);

   logic [N_PADS-1:0] hiz_fan;

   assign hiz_fan = {N_PADS{bus.hiz_all}};

   for (genvar i = 0; i < N_PADS; i++) begin : g_chan
      pad_bank_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LEN    (FILT_LEN),
         .TURN_CYCLES (TURN_CYCLES),
         .IDLE_BIT    (IDLE_VAL[i])
      ) u_chan (
         .clock   (clock),
         .reset   (reset),
         .out_val (bus.out_val[i]),
         .oe_req  (bus.oe_req[i]),
         .hiz     (hiz_fan[i]),
         .pad_i   (bus.pad_i[i]),
         .in_val  (bus.in_val[i]),
         .in_rise (bus.in_rise[i]),
         .in_fall (bus.in_fall[i]),
         .drv     (bus.drv[i]),
         .pad_o   (bus.pad_o[i]),
         .pad_t   (bus.pad_t[i])
      );
   end

endmodule

// File: tb/tb_pad_bank_io.sv
// Bench for pad_bank_io: directed scenarios plus random traffic, every cycle
// compared against a timestamp/queue-based reference model of the bank.
module tb_pad_bank_io;

   localparam int           N    = 4;
   localparam int           S    = 2;
   localparam int           F    = 3;
   localparam int           T    = 2;
   localparam logic [N-1:0] IDLE = 4'b0010;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   pad_bank_if #(.N_PADS(N)) bus ();
   pad_bank_if #(.N_PADS(N)) bus0 ();

   pad_bank_io #(
      .N_PADS(N), .SYNC_STAGES(S), .FILT_LEN(F), .TURN_CYCLES(T), .IDLE_VAL(IDLE)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   pad_bank_io #(
      .N_PADS(N), .SYNC_STAGES(S), .FILT_LEN(F), .TURN_CYCLES(0), .IDLE_VAL(IDLE)
   ) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0.slave)
   );

   assign bus0.out_val = bus.out_val;
   assign bus0.oe_req  = bus.oe_req;
   assign bus0.hiz_all = bus.hiz_all;
   assign bus0.pad_i   = bus.pad_i;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [N-1:0] m_filt, m_rise, m_fall, m_drv, m_drv0, m_pad_o;
   logic [N-1:0] dly[$];
   int           run[N];
   int           since[N];
   int           edge_no = 0;

   task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edge_no, obs, exp);
      end
   endtask

   // Drive is granted once the request has been seen on T+1 consecutive edges;
   // an input level is accepted once it has differed from the held level on F
   // consecutive non-driving edges, counted from the timestamp of the first one.
   task automatic modelEdge();
      logic [N-1:0] s_in;
      if (reset) begin
         m_filt  = IDLE;
         m_pad_o = '0;
         m_rise  = '0;
         m_fall  = '0;
         m_drv   = '0;
         m_drv0  = '0;
         dly.delete();
         for (int k = 0; k < S; k++) dly.push_back(IDLE);
         for (int i = 0; i < N; i++) begin
            run[i]   = 0;
            since[i] = -1;
         end
      end else begin
         s_in = dly[S-1];
         for (int i = 0; i < N; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (m_drv[i]) begin
               m_filt[i] = s_in[i];
               since[i]  = -1;
            end else if (s_in[i] == m_filt[i]) begin
               since[i] = -1;
            end else begin
               if (since[i] < 0) since[i] = edge_no;
               if (edge_no - since[i] + 1 >= F) begin
                  m_filt[i] = s_in[i];
                  m_rise[i] = s_in[i];
                  m_fall[i] = ~s_in[i];
                  since[i]  = -1;
               end
            end
            if (bus.oe_req[i] && !bus.hiz_all) begin
               if (run[i] < 1000) run[i]++;
            end else begin
               run[i] = 0;
            end
            m_drv[i]  = (run[i] >= T + 1);
            m_drv0[i] = (run[i] >= 1);
         end
         m_pad_o = bus.out_val;
         dly.push_front(bus.pad_i);
         void'(dly.pop_back());
      end
      edge_no++;
   endtask

   task automatic stepCycle();
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput("pad_t",   bus.pad_t,   ~m_drv);
      checkOutput("drv",     bus.drv,     m_drv);
      checkOutput("pad_o",   bus.pad_o,   m_pad_o);
      checkOutput("in_val",  bus.in_val,  (m_filt & ~m_drv) | (IDLE & m_drv));
      checkOutput("in_rise", bus.in_rise, m_rise & ~m_drv);
      checkOutput("in_fall", bus.in_fall, m_fall & ~m_drv);
      checkOutput("pad_t_turn0", bus0.pad_t, ~m_drv0);
      @(negedge clock);
   endtask

   task automatic applyStimulus(input logic rst, input logic [N-1:0] ov, input logic [N-1:0] oe,
                                input logic hz, input logic [N-1:0] pi, input int cycles);
      reset       = rst;
      bus.out_val = ov;
      bus.oe_req  = oe;
      bus.hiz_all = hz;
      bus.pad_i   = pi;
      for (int c = 0; c < cycles; c++) stepCycle();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pad_t"},  bus.pad_t,   4'b1111);
      checkOutput({tag, "_pad_o"},  bus.pad_o,   4'b0000);
      checkOutput({tag, "_in_val"}, bus.in_val,  4'b0010);
      checkOutput({tag, "_drv"},    bus.drv,     4'b0000);
      checkOutput({tag, "_rise"},   bus.in_rise, 4'b0000);
      checkOutput({tag, "_fall"},   bus.in_fall, 4'b0000);
   endtask

   initial begin
      logic [N-1:0] ov, oe, pi;
      logic         hz, rst;

      reset = 1'b1;
      bus.out_val = '0;
      bus.oe_req  = '0;
      bus.hiz_all = 1'b0;
      bus.pad_i   = '0;
      @(negedge clock);

      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3);
      checkResetState("reset");
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1);
      checkResetState("release");
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8);

      // Stable rise on pad 0 lands exactly S+F edges later
      for (int n = 1; n <= 6; n++) begin
         applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1);
         if (n == 4) checkOutput("lat_before", bus.in_val & 4'b0001, 4'b0000);
         if (n == 5) begin
            checkOutput("lat_val",  bus.in_val & 4'b0001,  4'b0001);
            checkOutput("lat_rise", bus.in_rise & 4'b0001, 4'b0001);
         end
         if (n == 6) checkOutput("lat_rise_end", bus.in_rise & 4'b0001, 4'b0000);
      end

      // Two-cycle glitch on pad 2 is rejected
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0101, 2);
      for (int n = 0; n < 6; n++) begin
         applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1);
         checkOutput("glitch_val",  bus.in_val & 4'b0100,  4'b0000);
         checkOutput("glitch_rise", bus.in_rise & 4'b0100, 4'b0000);
      end

      // Turnaround on pad 1
      for (int n = 1; n <= 3; n++) begin
         applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0001, 1);
         if (n == 1) checkOutput("turn0_drive", bus0.pad_t & 4'b0010, 4'b0000);
         if (n < 3) checkOutput("turn_wait", bus.pad_t & 4'b0010, 4'b0010);
         else begin
            checkOutput("turn_drive",  bus.pad_t & 4'b0010,  4'b0000);
            checkOutput("drive_inval", bus.in_val & 4'b0010, 4'b0010);
         end
      end
      applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0001, 2);
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1);
      checkOutput("release_t",    bus.pad_t & 4'b0010,   4'b0010);
      checkOutput("release_val",  bus.in_val & 4'b0010,  4'b0000);
      checkOutput("release_fall", bus.in_fall & 4'b0010, 4'b0000);

      // Output data path ignores oe_req
      applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0001, 1);
      checkOutput("pad_o_hiz", bus.pad_o, 4'b1010);
      applyStimulus(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0001, 1);
      checkOutput("pad_o_req", bus.pad_o, 4'b0101);

      // hiz_all override and full re-turnaround
      applyStimulus(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0001, 3);
      checkOutput("all_drive", bus.pad_t, 4'b0000);
      applyStimulus(1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 1);
      checkOutput("hiz_all", bus.pad_t, 4'b1111);
      for (int n = 1; n <= 3; n++) begin
         applyStimulus(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0001, 1);
         checkOutput("rehiz_t", bus.pad_t, (n < 3) ? 4'b1111 : 4'b0000);
      end

      // Reset in mid-WAIT with pad 3 mid-filter
      applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b1001, 1);
      applyStimulus(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b1001, 2);
      applyStimulus(1'b1, 4'b0101, 4'b1111, 1'b0, 4'b1001, 1);
      checkResetState("mid_reset");
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8);

      // Random traffic
      ov = '0; oe = '0; pi = '0;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         hz  = ($urandom_range(0, 19) == 0);
         ov  = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) oe[i] = ~oe[i];
            if ($urandom_range(0, 3) == 0) pi[i] = ~pi[i];
         end
         applyStimulus(rst, ov, oe, hz, pi, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_bank_io.md
PAD_BANK_IO -- requirements
Module: pad_bank_io

Interface
REQ-001 Parameter N_PADS, default 4: number of bidirectional pad channels.
REQ-002 Parameter SYNC_STAGES, default 2, min 2: input synchroniser depth.
REQ-003 Parameter FILT_LEN, default 3, min 1: consecutive cycles of a new input level required before acceptance.
REQ-004 Parameter TURN_CYCLES, default 2, min 0: idle cycles inserted between HIZ and DRIVE.
REQ-005 Parameter IDLE_VAL, width N_PADS, default 0: value presented on in_val for a pad while it is driving.
REQ-006 clock  input  1  sole clock; all logic rising-edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 out_val  input  N_PADS  core data to drive per pad.
REQ-009 oe_req  input  N_PADS  core request to drive per pad.
REQ-010 hiz_all  input  1  forces every pad to high-Z, overriding oe_req.
REQ-011 in_val  output  N_PADS  synchronised, filtered pad input level.
REQ-012 in_rise  output  N_PADS  one-cycle pulse when in_val goes 0->1.
REQ-013 in_fall  output  N_PADS  one-cycle pulse when in_val goes 1->0.
REQ-014 drv  output  N_PADS  1 while the pad is in DRIVE.
REQ-015 pad_o  output  N_PADS  pad output data, to I-buffer input.
REQ-016 pad_t  output  N_PADS  tristate control, 1 = high-Z, matches I/O buffer T polarity.
REQ-017 pad_i  input  N_PADS  raw asynchronous pad input.

Function
REQ-018 Each pad SHALL run an independent FSM with states HIZ, WAIT, DRIVE.
REQ-019 HIZ: oe_req=1 and hiz_all=0 -> WAIT when TURN_CYCLES>0, else DRIVE.
REQ-020 WAIT SHALL last exactly TURN_CYCLES cycles, then -> DRIVE; oe_req=0 or hiz_all=1 during WAIT -> HIZ next cycle.
REQ-021 DRIVE: oe_req=0 or hiz_all=1 -> HIZ next cycle, with no turnaround.
REQ-022 pad_t SHALL be 0 only in DRIVE, decoded from the state register; drv equals ~pad_t.
REQ-023 pad_o SHALL be out_val registered once (1-cycle latency), independent of state.
REQ-024 pad_i SHALL pass through SYNC_STAGES flops before any other use.
REQ-025 Filter: per-pad counter increments while synced value != filtered state and clears when equal; on reaching FILT_LEN, filtered state takes synced value and counter clears.
REQ-026 Stable pad_i change SHALL appear on in_val exactly SYNC_STAGES+FILT_LEN cycles later; pulses shorter than FILT_LEN cycles after sync SHALL be rejected.
REQ-027 in_rise/in_fall SHALL assert in the same cycle in_val changes, for one cycle.
REQ-028 In DRIVE: in_val[i]=IDLE_VAL[i], in_rise[i]=in_fall[i]=0, filter counter held 0, filtered state loaded each cycle with synced value.
REQ-029 Leaving DRIVE SHALL NOT produce an edge pulse for the IDLE_VAL->filtered-level step.
REQ-030 hiz_all SHALL take precedence over oe_req in every state and hold all pads in HIZ while asserted.

Reset
REQ-031 On reset: all FSMs HIZ, pad_t all 1, drv 0, pad_o 0, sync flops and filtered state = IDLE_VAL, counters 0, in_rise/in_fall 0, in_val = IDLE_VAL.
REQ-032 Reset asserted in any state, including mid-WAIT or mid-filter count, SHALL apply REQ-031 on the next edge.

Structure
REQ-033 Package pad_bank_pkg SHALL hold the FSM state type (HIZ, WAIT, DRIVE) and counter-width helper constants.
REQ-034 Per-pad logic SHALL be sub-module pad_bank_chan, instantiated N_PADS times by a generate loop; top contains only hiz_all fan-out and bus wiring.
REQ-035 Counter widths SHALL be clog2-derived from FILT_LEN and TURN_CYCLES; no vendor primitives inside the block.

Verification (N_PADS=4, SYNC_STAGES=2, FILT_LEN=3, TURN_CYCLES=2, IDLE_VAL=4'b0010)
REQ-036 Reset release -> pad_t=4'b1111, pad_o=4'b0000, in_val=4'b0010, drv=0.
REQ-037 pad_i[0] 0->1 held -> in_val[0]=1 exactly 5 cycles later with single-cycle in_rise[0]; 2-cycle pulse on pad_i[2] -> no in_val/edge change.
REQ-038 oe_req[1]=1 sampled at edge k -> pad_t[1]=0 from edge k+3, in_val[1]=1, no edge pulses; oe_req[1]=0 -> pad_t[1]=1 after next edge; TURN_CYCLES=0 variant -> pad_t[1]=0 from k+1.
REQ-039 oe_req=4'b1111 in DRIVE, hiz_all=1 one cycle -> pad_t=4'b1111 next cycle; on release full 2-cycle WAIT before re-drive.
REQ-040 out_val=4'b1010 -> pad_o=4'b1010 one cycle later regardless of oe_req.
REQ-041 reset asserted during WAIT and during partial filter count -> REQ-031 values next cycle, no edge pulses.
